register_file_multiport: RTL and testbench

Parametrised multi-port register file, successor to the single-port `register_file`. It adds:
- `NUM_READ_PORTS` independent registered read ports, with write-first bypass;
- a per-bit write mask;
- out-of-range address detection;
- a hardware clear sequencer.

The first `NUM_EXPOSED` entries stay continuously visible to downstream control logic. The block sits between the system controller's configuration path and datapath consumers that need simultaneous register reads.

---
 rtl/register_file_multiport_pkg.sv | 14 +
 rtl/register_file_read_port.sv | 57 +++++
 rtl/register_file_multiport.sv | 127 ++++++++++++
 tb/tb_register_file_multiport.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/register_file_multiport_pkg.sv
// Shared types and helpers for the multi-port register file.
package register_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  // Low bit of element `index` inside a packed vector of `width`-bit elements.
  function automatic int slice_lo(input int index, input int width);
    return index * width;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: range check, write-first bypass and output registers.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int AW                  = $clog2(REGISTER_FILE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  busy,
  input  logic                  read_enable,
  input  logic [AW-1:0]         read_address,
  input  logic                  bypass_en,
  input  logic [AW-1:0]         bypass_address,
  input  logic [DATA_WIDTH-1:0] bypass_data,
  input  logic [DATA_WIDTH-1:0] mem [REGISTER_FILE_DEPTH],
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_data_valid,
  output logic                  range_error
);

  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(REGISTER_FILE_DEPTH);

  logic                  in_range;
  logic                  fire;
  logic [DATA_WIDTH-1:0] rdata_p0;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic                  vld_p1;

  assign in_range    = {1'b0, read_address} < DEPTH_EXT;
  assign fire        = read_enable && !busy;
  assign range_error = fire && !in_range;

  always_comb begin
    rdata_p0 = '0;
    if (in_range)
      rdata_p0 = (bypass_en && (bypass_address == read_address)) ? bypass_data
                                                                 : mem[read_address];
  end

  // p0 -> p1: registered read data and one-cycle valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= fire;
      if (fire)
        rdata_p1 <= rdata_p0;
    end
  end

  assign read_data       = rdata_p1;
  assign read_data_valid = vld_p1;

endmodule

// File: rtl/register_file_multiport.sv
// Multi-port register file: masked writes, N registered read ports, clear sweep.
module register_file_multiport
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int NUM_READ_PORTS      = 2,
  parameter int NUM_EXPOSED         = 4,
  parameter int AW                  = $clog2(REGISTER_FILE_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 write_enable,
  input  logic [AW-1:0]                        write_address,
  input  logic [DATA_WIDTH-1:0]                write_data,
  input  logic [DATA_WIDTH-1:0]                write_mask,
  input  logic [NUM_READ_PORTS-1:0]            read_enable,
  input  logic [NUM_READ_PORTS*AW-1:0]         read_address,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ_PORTS-1:0]            read_data_valid,
  input  logic                                 clear_start,
  output logic                                 busy,
  output logic                                 clear_done,
  output logic                                 address_error,
  output logic [NUM_EXPOSED*DATA_WIDTH-1:0]    registers_out
);

  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(REGISTER_FILE_DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(REGISTER_FILE_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [REGISTER_FILE_DEPTH];
  rf_state_e             state;
  logic [AW-1:0]         clr_idx;
  logic                  busy_r;
  logic                  clear_done_r;
  logic                  address_error_r;
  logic                  clearing;
  logic                  wr_in_range;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [NUM_READ_PORTS-1:0] rd_range_err;

  assign clearing    = (state == CLEAR);
  assign wr_in_range = {1'b0, write_address} < DEPTH_EXT;
  // A clear request in the same cycle takes priority and drops the write.
  assign wr_fire     = write_enable && !clearing && !clear_start && wr_in_range;
  assign wr_old      = wr_in_range ? mem[write_address] : '0;
  assign wr_merged   = (wr_old & ~write_mask) | (write_data & write_mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGISTER_FILE_DEPTH; i++)
        mem[i] <= '0;
    end else if (clearing) begin
      mem[clr_idx] <= '0;
    end else if (wr_fire) begin
      mem[write_address] <= wr_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      clr_idx      <= '0;
      busy_r       <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      clear_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy_r  <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state        <= IDLE;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      address_error_r <= 1'b0;
    else
      address_error_r <= (write_enable && !clearing && !wr_in_range) || (|rd_range_err);
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    register_file_read_port #(
      .DATA_WIDTH         (DATA_WIDTH),
      .REGISTER_FILE_DEPTH(REGISTER_FILE_DEPTH),
      .AW                 (AW)
    ) u_rd (
      .clk            (clk),
      .reset          (reset),
      .busy           (clearing),
      .read_enable    (read_enable[p]),
      .read_address   (read_address[slice_lo(p, AW) +: AW]),
      .bypass_en      (wr_fire),
      .bypass_address (write_address),
      .bypass_data    (wr_merged),
      .mem            (mem),
      .read_data      (read_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH]),
      .read_data_valid(read_data_valid[p]),
      .range_error    (rd_range_err[p])
    );
  end

  for (genvar k = 0; k < NUM_EXPOSED; k++) begin : g_exp
    assign registers_out[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] = mem[k];
  end

  assign busy          = busy_r;
  assign clear_done    = clear_done_r;
  assign address_error = address_error_r;

endmodule

// File: tb/tb_register_file_multiport.sv
// Directed bench: vector table for read/write/bypass plus hand sequences for clear and range.
module tb_register_file_multiport;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Depth-16 instance
  logic        we, cs;
  logic [3:0]  wa;
  logic [7:0]  wd, wm, ra;
  logic [1:0]  re;
  logic [15:0] rd;
  logic [1:0]  rv;
  logic        busy, cdone, aerr;
  logic [31:0] regs;

  // Depth-12 instance for out-of-range addresses
  logic        we_b, cs_b;
  logic [3:0]  wa_b;
  logic [7:0]  wd_b, wm_b, ra_b;
  logic [1:0]  re_b;
  logic [15:0] rd_b;
  logic [1:0]  rv_b;
  logic        busy_b, cdone_b, aerr_b;
  logic [31:0] regs_b;

  register_file_multiport dut (
    .clk(clk), .reset(reset), .write_enable(we), .write_address(wa), .write_data(wd),
    .write_mask(wm), .read_enable(re), .read_address(ra), .read_data(rd),
    .read_data_valid(rv), .clear_start(cs), .busy(busy), .clear_done(cdone),
    .address_error(aerr), .registers_out(regs)
  );

  register_file_multiport #(.REGISTER_FILE_DEPTH(12)) dut12 (
    .clk(clk), .reset(reset), .write_enable(we_b), .write_address(wa_b), .write_data(wd_b),
    .write_mask(wm_b), .read_enable(re_b), .read_address(ra_b), .read_data(rd_b),
    .read_data_valid(rv_b), .clear_start(cs_b), .busy(busy_b), .clear_done(cdone_b),
    .address_error(aerr_b), .registers_out(regs_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd, wm;
    logic [1:0] re;
    logic [3:0] ra0, ra1;
    logic [1:0] ev;
    logic [7:0] ed0, ed1, er3;
  } vec_t;

  vec_t vt[8];

  initial begin
    int nb, nd, s;

    vt[0] = '{1'b1, 4'd14, 8'hF4, 8'hFF, 2'b00, 4'd0,  4'd0, 2'b00, 8'h00, 8'h00, 8'h00};
    vt[1] = '{1'b1, 4'd14, 8'h0B, 8'h0F, 2'b00, 4'd0,  4'd0, 2'b00, 8'h00, 8'h00, 8'h00};
    vt[2] = '{1'b0, 4'd0,  8'h00, 8'h00, 2'b01, 4'd14, 4'd0, 2'b01, 8'hFB, 8'h00, 8'h00};
    vt[3] = '{1'b1, 4'd2,  8'h11, 8'hFF, 2'b00, 4'd0,  4'd0, 2'b00, 8'hFB, 8'h00, 8'h00};
    vt[4] = '{1'b1, 4'd3,  8'h5A, 8'hFF, 2'b11, 4'd3,  4'd2, 2'b11, 8'h5A, 8'h11, 8'h5A};
    vt[5] = '{1'b0, 4'd0,  8'h00, 8'h00, 2'b00, 4'd0,  4'd0, 2'b00, 8'h5A, 8'h11, 8'h5A};
    vt[6] = '{1'b1, 4'd3,  8'h0F, 8'hF0, 2'b10, 4'd0,  4'd3, 2'b10, 8'h5A, 8'h0A, 8'h0A};
    vt[7] = '{1'b0, 4'd0,  8'h00, 8'h00, 2'b11, 4'd14, 4'd3, 2'b11, 8'hFB, 8'h0A, 8'h0A};

    reset = 1'b0;
    we = 0; cs = 0; wa = 0; wd = 0; wm = 0; re = 0; ra = 0;
    we_b = 0; cs_b = 0; wa_b = 0; wd_b = 0; wm_b = 0; re_b = 0; ra_b = 0;
    step(); step();
    chk("rst_read_data", 64'(rd), 64'h0);
    chk("rst_valid", 64'(rv), 64'h0);
    chk("rst_busy", 64'({busy, busy_b}), 64'h0);
    chk("rst_clear_done", 64'({cdone, cdone_b}), 64'h0);
    chk("rst_addr_err", 64'({aerr, aerr_b}), 64'h0);
    chk("rst_regs", 64'(regs), 64'h0);
    reset = 1'b1;
    step();

    // Masked write, dual read, write-first bypass
    for (int i = 0; i < 8; i++) begin
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd; wm = vt[i].wm;
      re = vt[i].re; ra = {vt[i].ra1, vt[i].ra0};
      step();
      chk($sformatf("vec%0d_valid", i), 64'(rv), 64'(vt[i].ev));
      chk($sformatf("vec%0d_data0", i), 64'(rd[7:0]), 64'(vt[i].ed0));
      chk($sformatf("vec%0d_data1", i), 64'(rd[15:8]), 64'(vt[i].ed1));
      chk($sformatf("vec%0d_regs3", i), 64'(regs[31:24]), 64'(vt[i].er3));
      chk($sformatf("vec%0d_aerr", i), 64'(aerr), 64'h0);
    end
    we = 0; re = 0;

    // Out-of-range on the depth-12 instance
    we_b = 1; wa_b = 4'd1; wd_b = 8'h44; wm_b = 8'hFF;
    step();
    chk("oor_inrange_write_aerr", 64'(aerr_b), 64'h0);
    wa_b = 4'd13; wd_b = 8'h77;
    step();
    chk("oor_write_aerr", 64'(aerr_b), 64'h1);
    chk("oor_write_regs", 64'(regs_b), 64'h0000_4400);
    we_b = 0;
    step();
    chk("oor_aerr_single", 64'(aerr_b), 64'h0);
    re_b = 2'b11; ra_b = {4'd1, 4'd1};
    step();
    chk("oor_pre_read", 64'({rv_b, rd_b}), 64'h3_4444);
    chk("oor_pre_aerr", 64'(aerr_b), 64'h0);
    re_b = 2'b10; ra_b = {4'd13, 4'd1};
    step();
    chk("oor_read_valid", 64'(rv_b), 64'h2);
    chk("oor_read_data1", 64'(rd_b[15:8]), 64'h00);
    chk("oor_read_data0_hold", 64'(rd_b[7:0]), 64'h44);
    chk("oor_read_aerr", 64'(aerr_b), 64'h1);
    re_b = 2'b11; ra_b = {4'd15, 4'd12};
    step();
    chk("oor_both_valid", 64'(rv_b), 64'h3);
    chk("oor_both_data", 64'(rd_b), 64'h0);
    chk("oor_both_aerr", 64'(aerr_b), 64'h1);
    re_b = 0;
    step();
    chk("oor_aerr_drop", 64'(aerr_b), 64'h0);
    chk("oor_valid_drop", 64'(rv_b), 64'h0);

    // Fill, then clear_start together with a write to entry 5
    for (int i = 0; i < 16; i++) begin
      we = 1; wa = 4'(i); wd = 8'hAA; wm = 8'hFF;
      step();
    end
    chk("fill_regs", 64'(regs), 64'hAAAA_AAAA);
    we = 1; wa = 4'd5; wd = 8'h33; wm = 8'hFF; cs = 1;
    step();
    we = 0; cs = 0; re = 2'b11; ra = {4'd5, 4'd0};
    nb = 0; nd = 0; s = 0;
    while (busy && nb < 40) begin
      nb++;
      chk($sformatf("clr_no_valid_%0d", s), 64'(rv), 64'h0);
      if (s == 2) chk("clr_regs_sweep", 64'(regs), 64'hAAAA_0000);
      if (cdone) nd++;
      cs = (s == 4);
      step();
      s++;
    end
    cs = 0;
    chk("clr_busy_cycles", 64'(nb), 64'd16);
    chk("clr_done_early", 64'(nd), 64'd0);
    chk("clr_done_pulse", 64'(cdone), 64'h1);
    chk("clr_valid_end", 64'(rv), 64'h0);
    re = 0;
    step();
    chk("clr_done_drop", 64'(cdone), 64'h0);
    chk("clr_busy_idle", 64'(busy), 64'h0);
    for (int i = 0; i < 16; i++) begin
      re = 2'b11; ra = {4'(15 - i), 4'(i)};
      step();
      chk($sformatf("clr_read_entry%0d", i), 64'({rv, rd}), 64'h3_0000);
    end
    re = 0;

    // Reset in the middle of a sweep
    for (int i = 0; i < 4; i++) begin
      we = 1; wa = 4'(i); wd = 8'h5C; wm = 8'hFF;
      step();
    end
    we = 0; re = 2'b11; ra = {4'd3, 4'd0};
    step();
    chk("mid_pre_read", 64'(rd), 64'h5C5C);
    re = 0; cs = 1;
    step();
    cs = 0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_busy_before", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_data", 64'({rv, rd}), 64'h0);
    chk("mid_rst_regs", 64'(regs), 64'h0);
    chk("mid_rst_flags", 64'({cdone, aerr}), 64'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cdone || busy) nd++;
    end
    chk("mid_no_done", 64'(nd), 64'd0);
    we = 1; wa = 4'd7; wd = 8'h99; wm = 8'hFF;
    step();
    we = 0; re = 2'b01; ra = {4'd0, 4'd7};
    step();
    chk("mid_after_read", 64'({rv, rd[7:0]}), 64'h1_99);
    re = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
